// File: rtl/mem_wb_stage.sv
// Writeback stage: registers MEM results into the regfile write port and
// services loads with a WAIT state that stalls upstream until memory replies.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_load,
    input  logic [2:0]  mem_ld_op,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic        ld_pend,
    output logic [4:0]  ld_pend_addr,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lo_q, lo_d;
    logic [AW-1:0]     hwaddr_q, hwaddr_d;
    logic              hwreg_q, hwreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_we_q, wb_we_d;
    logic [AW-1:0]     wb_waddr_q, wb_waddr_d;
    logic [DW-1:0]     wb_wdata_q, wb_wdata_d;
    logic [AW-1:0]     pend_addr_q, pend_addr_d;
    logic              addr_err_q, addr_err_d;
    logic              bus_err_q, bus_err_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DW-1:0]     ld_ext;
    logic              misaligned;

    // Little-endian byte/half extraction of the returned word
    always_comb begin
        byte_sel = dmem_rdata[{lo_q, 3'b000} +: 8];
        half_sel = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_ext = {24'h0, byte_sel};
            OP_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_ext = {16'h0, half_sel};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Reserved opcodes are treated like misaligned accesses and dropped
    always_comb begin
        case (mem_ld_op)
            OP_LB, OP_LBU:  misaligned = 1'b0;
            OP_LH, OP_LHU:  misaligned = mem_addr_lo[0];
            OP_LW:          misaligned = (mem_addr_lo != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lo_d        = lo_q;
        hwaddr_d    = hwaddr_q;
        hwreg_d     = hwreg_q;
        cnt_d       = cnt_q;
        wb_we_d     = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        pend_addr_d = pend_addr_q;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_valid && !mem_load) begin
                        wb_we_d = mem_wreg && (mem_waddr != '0);
                        if (wb_we_d) begin
                            wb_waddr_d = mem_waddr;
                            wb_wdata_d = mem_wdata;
                        end
                    end else if (mem_valid && mem_load) begin
                        if (misaligned) begin
                            addr_err_d = 1'b1;
                        end else begin
                            op_d        = mem_ld_op;
                            lo_d        = mem_addr_lo;
                            hwaddr_d    = mem_waddr;
                            hwreg_d     = mem_wreg;
                            cnt_d       = '0;
                            pend_addr_d = mem_waddr;
                            state_d     = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_we_d = hwreg_q && (hwaddr_q != '0);
                        if (wb_we_d) begin
                            wb_waddr_d = hwaddr_q;
                            wb_wdata_d = ld_ext;
                        end
                        state_d = IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            lo_q        <= '0;
            hwaddr_q    <= '0;
            hwreg_q     <= 1'b0;
            cnt_q       <= '0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            pend_addr_q <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            hwaddr_q    <= hwaddr_d;
            hwreg_q     <= hwreg_d;
            cnt_q       <= cnt_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            pend_addr_q <= pend_addr_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign wb_we        = wb_we_q;
    assign wb_waddr     = wb_waddr_q;
    assign wb_wdata     = wb_wdata_q;
    assign stall_req    = (state_q == WAIT);
    assign ld_pend      = (state_q == WAIT);
    assign ld_pend_addr = pend_addr_q;
    assign addr_err     = addr_err_q;
    assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback stage directly upstream of the register file; drives its write port (w1_ena/w1_addr/w1_data).
- Registers MEM-stage results; for loads, waits on data memory and sign/zero-extends the returned byte/half/word.
- Stalls the pipeline while a load is outstanding.
- Flags misaligned loads and memory timeouts.

Parameters:
- TIMEOUT, 255: max WAIT cycles before a load is abandoned (1..65535).
- CNT_W, 16: width of the wait counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of the in-flight instruction
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_wreg  in  1  instruction writes a GPR
- mem_waddr  in  5  destination register
- mem_wdata  in  32  ALU result (non-load)
- mem_load  in  1  instruction is a load
- mem_ld_op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW, others reserved
- mem_addr_lo  in  2  load address bits [1:0]
- dmem_rdata  in  32  aligned memory word
- dmem_rvalid  in  1  dmem_rdata valid this cycle
- wb_we  out  1  to regfile w1_ena
- wb_waddr  out  5  to regfile w1_addr
- wb_wdata  out  32  to regfile w1_data
- stall_req  out  1  hold IF..MEM stages
- ld_pend  out  1  load outstanding (hazard unit)
- ld_pend_addr  out  5  destination of outstanding load
- addr_err  out  1  one-cycle pulse: misaligned load dropped
- bus_err  out  1  one-cycle pulse: load timed out

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; held regs and counter 0.
- States: IDLE, WAIT. All outputs registered; stall_req = (state==WAIT), ld_pend = (state==WAIT).
- IDLE, mem_valid=1, mem_load=0:
  - next edge: wb_we <= mem_wreg && (mem_waddr!=0); wb_waddr <= mem_waddr; wb_wdata <= mem_wdata.
  - Latency 1 cycle.
- IDLE, mem_valid=1, mem_load=1:
  - Misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0), or reserved op: wb_we <= 0, addr_err <= 1 for one cycle, stay IDLE.
  - Otherwise: capture op, addr_lo, waddr, wreg into held regs; wb_we <= 0; counter <= 0; ld_pend_addr <= mem_waddr; state <= WAIT.
- IDLE, mem_valid=0: wb_we <= 0.
- dmem_rvalid in IDLE is ignored.
- WAIT:
  - mem_* inputs are ignored; upstream is held by stall_req.
  - dmem_rvalid=1: wb_we <= held_wreg && (held_waddr!=0); wb_waddr <= held_waddr; wb_wdata <= extracted value; state <= IDLE.
  - Stall drops the following cycle, so one bubble per load.
  - dmem_rvalid=0: counter++. When counter==TIMEOUT-1 and still no rvalid: bus_err <= 1 (one cycle), wb_we <= 0, state <= IDLE, load dropped.
- Extraction (little-endian; byte k = rdata[8k+7:8k]):
  - LB sign-extends the byte, LBU zero-extends it.
  - LH sign-extends half addr_lo[1] (bits [15:0] or [31:16]), LHU zero-extends it.
  - LW passes the word.
- flush=1 (synchronous, any state):
  - wb_we <= 0; state <= IDLE; counter cleared; held load discarded.
  - flush has priority over dmem_rvalid, timeout and a new MEM instruction.
- Writes to $0 never assert wb_we.
- wb_waddr/wb_wdata update whenever wb_we is set; otherwise they hold their value.
- addr_err and bus_err are never asserted in the same cycle.

Test Plan:
- Reset mid-WAIT: load pending, assert rst asynchronously between edges -> wb_we, stall_req, ld_pend drop to 0 immediately; state IDLE after release.
- ALU writeback: mem_valid=1, mem_wreg=1, waddr=5, wdata=0x1234_5678 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x1234_5678, stall_req=0. Same with waddr=0 -> wb_we=0.
- Load extraction, rdata=0x80FF_7F81, rvalid 3 cycles after issue:
  - stall_req high 3 cycles.
  - LB addr_lo=0 -> 0xFFFF_FF81; LBU addr_lo=3 -> 0x0000_0080.
  - LH addr_lo=2 -> 0xFFFF_80FF; LHU addr_lo=0 -> 0x0000_7F81; LW -> 0x80FF_7F81.
- Misalignment: LW addr_lo=2 -> addr_err pulse 1 cycle, wb_we=0, no WAIT entry. LH addr_lo=1 -> same.
- Timeout: TIMEOUT=4, no rvalid -> bus_err after 4 WAIT cycles, wb_we=0, stall_req released next cycle. Late rvalid afterwards is ignored.
- Flush/rvalid collision: in WAIT, assert flush and dmem_rvalid together -> wb_we=0, state IDLE, no write. Back-to-back ALU then load then ALU -> writes in program order, no instruction lost during stall.
